// File: rtl/sequential_multiply_pkg.sv
// rtl/sequential_multiply_pkg.sv - shared state encoding and width constants for the shift-add multiplier
package sequential_multiply_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int SEQ_MUL_DEFAULT_WIDTH = 32;
   localparam int SEQ_MUL_DEFAULT_CNT_W = $clog2(SEQ_MUL_DEFAULT_WIDTH + 1);

   // Iteration counter must hold the value WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sequential_multiply_cond_negate.sv
// rtl/sequential_multiply_cond_negate.sv - conditional two's complement negation
module cond_negate #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/sequential_multiply.sv
// rtl/sequential_multiply.sv - radix-2 shift-add multiplier, WIDTH+1 cycle latency
// Optional early termination on an exhausted multiplier: SEQ_MUL_EARLY_TERM_EN
module sequential_multiply
   import sequential_multiply_pkg::*;
#(
   parameter int WIDTH = SEQ_MUL_DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               ready,
   output logic               done
);

   localparam int CW = cnt_width(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t          state, state_nxt;
   logic [PW-1:0]   mcand_reg;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   acc_fix;
   logic [WIDTH-1:0] mplier_reg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [CW-1:0]   count;
   logic            neg_reg;
   logic            mplier_zero;

   cond_negate #(.W(WIDTH)) u_mag_a (
      .x   (multiplicand),
      .neg (sign & multiplicand[WIDTH-1]),
      .y   (a_mag)
   );

   cond_negate #(.W(WIDTH)) u_mag_b (
      .x   (multiplier),
      .neg (sign & multiplier[WIDTH-1]),
      .y   (b_mag)
   );

   cond_negate #(.W(PW)) u_fix_p (
      .x   (acc),
      .neg (neg_reg),
      .y   (acc_fix)
   );

`ifdef SEQ_MUL_EARLY_TERM_EN
   // No set bits left means every remaining iteration would add nothing.
   assign mplier_zero = (mplier_reg == '0);
`else
   assign mplier_zero = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = RUN;
         end
         RUN:     if (mplier_zero || count == CW'(1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc        <= '0;
         count      <= '0;
         neg_reg    <= 1'b0;
         product    <= '0;
         done       <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
               mplier_reg <= b_mag;
               acc        <= '0;
               count      <= CW'(WIDTH);
               neg_reg    <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            end
            RUN: begin
               if (mplier_reg[0]) acc <= acc + mcand_reg;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               count      <= count - CW'(1);
            end
            FIX: begin
               product <= acc_fix;
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequential_multiply.sv
// tb/tb_sequential_multiply.sv - scoreboard bench for sequential_multiply
module tb_sequential_multiply;

   localparam int W = 32;
`ifdef SEQ_MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           sign;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] product;
   logic           ready;
   logic           done;

   int vectors     = 0;
   int miscompares = 0;

   logic [2*W-1:0] exp_q[$];
   int             lat_q[$];

   always #5 clk = ~clk;

   sequential_multiply #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .sign         (sign),
      .multiplicand (a),
      .multiplier   (b),
      .product      (product),
      .ready        (ready),
      .done         (done)
   );

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [63:0] xe, ye;
      xe = s ? {{32{x[31]}}, x} : {32'b0, x};
      ye = s ? {{32{y[31]}}, y} : {32'b0, y};
      return xe * ye;
   endfunction

   function automatic int model_lat(input logic [31:0] y, input logic s);
      logic [31:0] m;
      int hi, early;
      m  = (s && y[31]) ? (~y + 32'd1) : y;
      hi = -1;
      for (int i = 0; i < 32; i++) if (m[i]) hi = i;
      early = (hi < 0) ? 2 : ((hi + 3 < W + 1) ? hi + 3 : W + 1);
      return EARLY ? early : W + 1;
   endfunction

   // Drives one start pulse across an edge in IDLE and records the expected outcome.
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
      @(negedge clk);
      a = x; b = y; sign = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(model(x, y, s));
      lat_q.push_back(model_lat(y, s));
   endtask

   // Returns cycles from the accepting edge to done (-1 on timeout) and count of ready-high samples before it.
   task automatic wait_done(output int lat, output int rdy_hi);
      lat = -1; rdy_hi = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            return;
         end
         if (ready !== 1'b0) rdy_hi++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (product !== 64'd0) begin miscompares++; $display("FAIL reset_product got=%h want=0", product); end
      vectors++;
      if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", ready); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic;
      logic [63:0] e; int el, lat, rh;
      issue(32'd7, 32'd6, 1'b0);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      wait_done(lat, rh);
      vectors++;
      if (product !== 64'h2A || product !== e) begin miscompares++; $display("FAIL basic_product got=%h want=%h", product, 64'h2A); end
      vectors++;
      if (lat !== 33 || lat !== el) begin miscompares++; $display("FAIL basic_latency got=%0d want=33", lat); end
      vectors++;
      if (rh !== 0) begin miscompares++; $display("FAIL basic_ready_low got=%0d high samples want=0", rh); end
      vectors++;
      if (ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_at_done got=%b want=1", ready); end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got=%b want=0", done); end
   endtask

   task automatic test_signed_table;
      logic [31:0] x, y; logic s; logic [63:0] lit, e; int el, lat, rh;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       begin x = 32'hFFFFFFFD; y = 32'd5;        s = 1'b1; lit = 64'hFFFFFFFFFFFFFFF1; end
            1:       begin x = 32'hFFFFFFFD; y = 32'd5;        s = 1'b0; lit = 64'h4FFFFFFF1;        end
            2:       begin x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; s = 1'b0; lit = 64'hFFFFFFFE00000001; end
            default: begin x = 32'h80000000; y = 32'h80000000; s = 1'b1; lit = 64'h4000000000000000; end
         endcase
         issue(x, y, s);
         e = exp_q.pop_front(); el = lat_q.pop_front();
         wait_done(lat, rh);
         vectors++;
         if (product !== lit || e !== lit) begin miscompares++; $display("FAIL table%0d_product got=%h want=%h", i, product, lit); end
         vectors++;
         if (lat !== el) begin miscompares++; $display("FAIL table%0d_latency got=%0d want=%0d", i, lat, el); end
      end
   endtask

   task automatic test_random;
      logic [63:0] e; int el, lat, rh;
      for (int i = 0; i < 8; i++) begin
         issue($urandom, (i == 3) ? 32'd0 : $urandom >> (4 * i), 1'(i % 2));
         e = exp_q.pop_front(); el = lat_q.pop_front();
         wait_done(lat, rh);
         vectors++;
         if (product !== e) begin miscompares++; $display("FAIL rand%0d_product got=%h want=%h", i, product, e); end
         vectors++;
         if (lat !== el) begin miscompares++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, el); end
      end
   endtask

   task automatic test_ignore_start;
      logic [63:0] e; int el, lat, rh;
      issue(32'd3, 32'd4, 1'b0);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      repeat (4) @(negedge clk);
      a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, rh);
      vectors++;
      if (product !== 64'd12 || e !== 64'd12) begin miscompares++; $display("FAIL ignore_product got=%h want=c", product); end
      vectors++;
      if (lat + 5 !== el) begin miscompares++; $display("FAIL ignore_latency got=%0d want=%0d", lat + 5, el); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] e; int el, lat, rh;
      @(negedge clk);
      a = 32'd3; b = 32'd4; sign = 1'b0; start = 1'b1;
      @(negedge clk);
      exp_q.push_back(model(32'd3, 32'd4, 1'b0)); lat_q.push_back(model_lat(32'd4, 1'b0));
      a = 32'd11; b = 32'd13;
      wait_done(lat, rh);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      vectors++;
      if (product !== e) begin miscompares++; $display("FAIL b2b_first_product got=%h want=%h", product, e); end
      vectors++;
      if (lat !== el) begin miscompares++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, el); end
      exp_q.push_back(model(32'd11, 32'd13, 1'b0)); lat_q.push_back(model_lat(32'd13, 1'b0));
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got=%b ready want=0", ready); end
      wait_done(lat, rh);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      vectors++;
      if (product !== 64'd143 || e !== 64'd143) begin miscompares++; $display("FAIL b2b_second_product got=%h want=8f", product); end
      vectors++;
      if (lat !== el) begin miscompares++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, el); end
   endtask

   task automatic test_early_term;
      logic [31:0] x, y; logic [63:0] lit, e; int el, lat, rh;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin x = 32'd7; y = 32'd0;        lit = 64'd0;           end
            1:       begin x = 32'd5; y = 32'd1;        lit = 64'd5;           end
            default: begin x = 32'd3; y = 32'h80000000; lit = 64'h180000000;  end
         endcase
         issue(x, y, 1'b0);
         e = exp_q.pop_front(); el = lat_q.pop_front();
         wait_done(lat, rh);
         vectors++;
         if (product !== lit || e !== lit) begin miscompares++; $display("FAIL early%0d_product got=%h want=%h", i, product, lit); end
         vectors++;
         if (lat !== (EARLY ? ((i == 0) ? 2 : (i == 1) ? 3 : 33) : 33)) begin
            miscompares++; $display("FAIL early%0d_latency got=%0d want=%0d", i, lat, el);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      logic [63:0] e; int el, lat, rh, spurious;
      issue(32'd123, 32'd456, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (product !== 64'd0) begin miscompares++; $display("FAIL abort_product got=%h want=0", product); end
      vectors++;
      if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got=%b want=1", ready); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b want=0", done); end
      exp_q.delete(); lat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) spurious++;
      end
      vectors++;
      if (spurious !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d pulses want=0", spurious); end
      issue(32'd21, 32'd2, 1'b0);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      wait_done(lat, rh);
      vectors++;
      if (product !== 64'd42 || e !== 64'd42) begin miscompares++; $display("FAIL abort_recover_product got=%h want=2a", product); end
      vectors++;
      if (lat !== el) begin miscompares++; $display("FAIL abort_recover_latency got=%0d want=%0d", lat, el); end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed_table();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_early_term();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
